// File: rtl/multi_duck_game_logic.sv
// rtl/multi_duck_game_logic.sv - Duck Hunt round controller: ammo, score, hit test and phase FSM
//
// Purpose: tracks magazine and ammo pool, detects mouse button edges, tests
// the cursor against every active duck hitbox (lowest index wins), keeps a
// saturating kill score and sequences the round phases IDLE, COUNTDOWN,
// HUNTING, RELOADING, DEATH_DELAY and GAME_OVER.
//
// Optional feature: define GAME_AUTO_RELOAD_EN to reload automatically when a
// shot empties the magazine while rounds remain (the reload indicator then
// never rises). Without it only a right click reloads.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   mouse_xpos, mouse_ypos     cursor position (12 bit each)
//   left_mouse, right_mouse    shoot / reload button levels
//   game_enable                1 = game running, 0 = abort to IDLE
//   duck_xpos, duck_ypos       packed duck positions, duck i at [12*i +: 12]
//   duck_active                per-duck shootable flag
//   bullets_in_magazine        rounds currently loaded
//   bullets_left               total rounds remaining, magazine included
//   my_score                   saturating kill count
//   hunt_start                 high in HUNTING and RELOADING
//   show_reload_char           high while magazine empty and rounds remain
//   duck_killed                one-cycle kill pulse per duck
//   game_over                  high in GAME_OVER
module multi_duck_game_logic #(
  parameter int NUM_DUCKS     = 2,
  parameter int MAG_SIZE      = 3,
  parameter int TOTAL_AMMO    = 27,
  parameter int DUCK_W        = 96,
  parameter int DUCK_H        = 60,
  parameter int COUNTDOWN_CYC = 130_000_000,
  parameter int DEATH_CYC     = 130_000_000,
  parameter int RELOAD_CYC    = 65_000,
  parameter int SCORE_W       = 7
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [11:0]                     mouse_xpos,
  input  logic [11:0]                     mouse_ypos,
  input  logic                            left_mouse,
  input  logic                            right_mouse,
  input  logic                            game_enable,
  input  logic [12*NUM_DUCKS-1:0]         duck_xpos,
  input  logic [12*NUM_DUCKS-1:0]         duck_ypos,
  input  logic [NUM_DUCKS-1:0]            duck_active,
  output logic [$clog2(MAG_SIZE+1)-1:0]   bullets_in_magazine,
  output logic [$clog2(TOTAL_AMMO+1)-1:0] bullets_left,
  output logic [SCORE_W-1:0]              my_score,
  output logic                            hunt_start,
  output logic                            show_reload_char,
  output logic [NUM_DUCKS-1:0]            duck_killed,
  output logic                            game_over
);

  localparam int MAG_W   = $clog2(MAG_SIZE+1);
  localparam int LEFT_W  = $clog2(TOTAL_AMMO+1);
  localparam int CNT_MAX = (COUNTDOWN_CYC > DEATH_CYC)
                         ? ((COUNTDOWN_CYC > RELOAD_CYC) ? COUNTDOWN_CYC : RELOAD_CYC)
                         : ((DEATH_CYC > RELOAD_CYC) ? DEATH_CYC : RELOAD_CYC);
  localparam int CNT_W   = $clog2(CNT_MAX+1);

  localparam logic [MAG_W-1:0]   MAG_FULL  = MAG_W'(MAG_SIZE);
  localparam logic [LEFT_W-1:0]  AMMO_FULL = LEFT_W'(TOTAL_AMMO);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

`ifdef GAME_AUTO_RELOAD_EN
  localparam bit AUTO_RELOAD = 1'b1;
`else
  localparam bit AUTO_RELOAD = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNTDOWN,
    S_HUNTING,
    S_RELOADING,
    S_DEATH_DELAY,
    S_GAME_OVER
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [MAG_W-1:0]     mag_q, mag_d;
  logic [LEFT_W-1:0]    left_q, left_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic                 left_prev_q, right_prev_q;
  logic                 hunt_start_q, hunt_start_d;
  logic                 show_reload_q, show_reload_d;
  logic                 game_over_q, game_over_d;
  logic [NUM_DUCKS-1:0] kill_q, kill_d;

  logic                 left_pe, right_pe;
  logic                 reload_ok;
  logic [NUM_DUCKS-1:0] hit_vec;
  logic                 hit_any;
  logic [12:0]          mx, my;

  // Magazine contents after a reload: as many rounds as fit, never more than remain.
  function automatic logic [MAG_W-1:0] reload_fill(input logic [LEFT_W-1:0] rounds);
    if (32'(rounds) >= 32'(MAG_SIZE)) begin
      return MAG_FULL;
    end
    return MAG_W'(rounds);
  endfunction

  assign left_pe  = left_mouse  & ~left_prev_q;
  assign right_pe = right_mouse & ~right_prev_q;

  // Reload only makes sense if it would actually add rounds to the magazine.
  assign reload_ok = (32'(mag_q) < 32'(MAG_SIZE)) && (32'(left_q) > 32'(mag_q));

  // Hitbox compare is done one bit wider so a duck near the right/bottom
  // screen edge does not wrap its far boundary back to small coordinates.
  assign mx = {1'b0, mouse_xpos};
  assign my = {1'b0, mouse_ypos};

  always_comb begin
    hit_vec = '0;
    hit_any = 1'b0;
    for (int i = 0; i < NUM_DUCKS; i++) begin
      if (!hit_any && duck_active[i]
          && (mx >= {1'b0, duck_xpos[12*i +: 12]})
          && (mx <  ({1'b0, duck_xpos[12*i +: 12]} + 13'(DUCK_W)))
          && (my >= {1'b0, duck_ypos[12*i +: 12]})
          && (my <  ({1'b0, duck_ypos[12*i +: 12]} + 13'(DUCK_H)))) begin
        hit_vec[i] = 1'b1;
        hit_any    = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_d   = mag_q;
    left_d  = left_q;
    score_d = score_q;
    kill_d  = '0;

    if (!game_enable) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      mag_d   = MAG_FULL;
      left_d  = AMMO_FULL;
      score_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_COUNTDOWN;
          cnt_d   = CNT_W'(COUNTDOWN_CYC);
          mag_d   = MAG_FULL;
          left_d  = AMMO_FULL;
          score_d = '0;
        end

        S_COUNTDOWN: begin
          if (cnt_q == '0) begin
            state_d = S_HUNTING;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_HUNTING: begin
          if (left_q == '0) begin
            state_d = S_GAME_OVER;
          end else if (left_pe && (mag_q != '0)) begin
            // A taken shot always wins over a same-cycle reload request.
            mag_d  = mag_q - MAG_W'(1);
            left_d = left_q - LEFT_W'(1);
            if (hit_any) begin
              kill_d  = hit_vec;
              state_d = S_DEATH_DELAY;
              cnt_d   = CNT_W'(DEATH_CYC);
              if (score_q != SCORE_MAX) begin
                score_d = score_q + SCORE_W'(1);
              end
            end else if (AUTO_RELOAD && (mag_q == MAG_W'(1)) && (left_q > LEFT_W'(1))) begin
              state_d = S_RELOADING;
              cnt_d   = CNT_W'(RELOAD_CYC);
              mag_d   = reload_fill(left_q - LEFT_W'(1));
            end
          end else if (right_pe && reload_ok) begin
            state_d = S_RELOADING;
            cnt_d   = CNT_W'(RELOAD_CYC);
            mag_d   = reload_fill(left_q);
          end
        end

        S_RELOADING: begin
          if (cnt_q == '0) begin
            state_d = S_HUNTING;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_DEATH_DELAY: begin
          if (cnt_q == '0) begin
            state_d = S_HUNTING;
            // A hit that emptied the magazine reloads once the pause is over.
            if (AUTO_RELOAD && (mag_q == '0) && (left_q != '0)) begin
              state_d = S_RELOADING;
              cnt_d   = CNT_W'(RELOAD_CYC);
              mag_d   = reload_fill(left_q);
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end

        S_GAME_OVER: begin
          state_d = S_GAME_OVER;
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    hunt_start_d  = (state_d == S_HUNTING) || (state_d == S_RELOADING);
    game_over_d   = (state_d == S_GAME_OVER);
    show_reload_d = !AUTO_RELOAD && (mag_d == '0) && (left_d != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      mag_q         <= MAG_FULL;
      left_q        <= AMMO_FULL;
      score_q       <= '0;
      left_prev_q   <= 1'b0;
      right_prev_q  <= 1'b0;
      hunt_start_q  <= 1'b0;
      show_reload_q <= 1'b0;
      game_over_q   <= 1'b0;
      kill_q        <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      mag_q         <= mag_d;
      left_q        <= left_d;
      score_q       <= score_d;
      left_prev_q   <= left_mouse;
      right_prev_q  <= right_mouse;
      hunt_start_q  <= hunt_start_d;
      show_reload_q <= show_reload_d;
      game_over_q   <= game_over_d;
      kill_q        <= kill_d;
    end
  end

  assign bullets_in_magazine = mag_q;
  assign bullets_left        = left_q;
  assign my_score            = score_q;
  assign hunt_start          = hunt_start_q;
  assign show_reload_char    = show_reload_q;
  assign duck_killed         = kill_q;
  assign game_over           = game_over_q;

endmodule

// File: tb/tb_multi_duck_game_logic.sv
// tb/tb_multi_duck_game_logic.sv - scoreboard bench for multi_duck_game_logic
`timescale 1ns/1ps
module tb_multi_duck_game_logic;

  localparam int ND  = 2;
  localparam int MAG = 3;
  localparam int TOT = 7;
  localparam int CD  = 40;
  localparam int DC  = 20;
  localparam int RC  = 5;
  localparam int DW  = 96;
  localparam int DH  = 60;
  localparam int SMAX = 127;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic        left_mouse = 1'b0;
  logic        right_mouse = 1'b0;
  logic        game_enable = 1'b0;
  logic [23:0] duck_xpos = '0;
  logic [23:0] duck_ypos = '0;
  logic [1:0]  duck_active = '0;
  logic [1:0]  bullets_in_magazine;
  logic [2:0]  bullets_left;
  logic [6:0]  my_score;
  logic        hunt_start;
  logic        show_reload_char;
  logic [1:0]  duck_killed;
  logic        game_over;

  always #5 clk = ~clk;

  multi_duck_game_logic #(
    .NUM_DUCKS(ND), .MAG_SIZE(MAG), .TOTAL_AMMO(TOT), .DUCK_W(DW), .DUCK_H(DH),
    .COUNTDOWN_CYC(CD), .DEATH_CYC(DC), .RELOAD_CYC(RC), .SCORE_W(7)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mouse_xpos(mouse_xpos), .mouse_ypos(mouse_ypos),
    .left_mouse(left_mouse), .right_mouse(right_mouse),
    .game_enable(game_enable),
    .duck_xpos(duck_xpos), .duck_ypos(duck_ypos), .duck_active(duck_active),
    .bullets_in_magazine(bullets_in_magazine), .bullets_left(bullets_left),
    .my_score(my_score), .hunt_start(hunt_start), .show_reload_char(show_reload_char),
    .duck_killed(duck_killed), .game_over(game_over)
  );

  int total = 0;
  int bad   = 0;

  function automatic void check(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  typedef struct {
    int mag;
    int left;
    int score;
    int hunt;
    int show;
    int over;
    int kill;
  } exp_t;

  exp_t exp_q[$];
  int   kill_q[$];

  // Reference model: round phase by name plus cycles remaining in that phase.
  string m_phase = "idle";
  int    m_rem   = 0;
  int    m_mag   = MAG;
  int    m_left  = TOT;
  int    m_score = 0;
  int    m_kill  = 0;
  bit    m_lprev = 0;
  bit    m_rprev = 0;

  function automatic int first_hit(int mx, int my);
    int dx, dy;
    for (int i = 0; i < ND; i++) begin
      dx = int'(duck_xpos[12*i +: 12]);
      dy = int'(duck_ypos[12*i +: 12]);
      if (duck_active[i] && mx >= dx && mx < dx + DW && my >= dy && my < dy + DH)
        return i;
    end
    return -1;
  endfunction

  task automatic model_reset_vals();
    m_mag   = MAG;
    m_left  = TOT;
    m_score = 0;
  endtask

  task automatic model_step();
    bit   lpe, rpe;
    int   h;
    exp_t e;
    lpe    = left_mouse && !m_lprev;
    rpe    = right_mouse && !m_rprev;
    m_kill = 0;
    if (!rst_n) begin
      m_phase = "idle";
      model_reset_vals();
      m_lprev = 0;
      m_rprev = 0;
    end else begin
      m_lprev = left_mouse;
      m_rprev = right_mouse;
      if (!game_enable) begin
        m_phase = "idle";
        model_reset_vals();
      end else if (m_phase == "idle") begin
        m_phase = "countdown";
        m_rem   = CD + 1;
      end else if (m_phase == "countdown" || m_phase == "reloading" || m_phase == "death") begin
        m_rem--;
        if (m_rem == 0) m_phase = "hunting";
      end else if (m_phase == "hunting") begin
        if (m_left == 0) begin
          m_phase = "over";
        end else if (lpe && m_mag > 0) begin
          m_mag--;
          m_left--;
          h = first_hit(int'(mouse_xpos), int'(mouse_ypos));
          if (h >= 0) begin
            m_kill  = 1 << h;
            m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
            m_phase = "death";
            m_rem   = DC + 1;
          end
        end else if (rpe && m_mag < MAG && m_left > m_mag) begin
          m_mag   = (m_left < MAG) ? m_left : MAG;
          m_phase = "reloading";
          m_rem   = RC + 1;
        end
      end
    end
    e.mag   = m_mag;
    e.left  = m_left;
    e.score = m_score;
    e.hunt  = (m_phase == "hunting" || m_phase == "reloading") ? 1 : 0;
    e.show  = (m_mag == 0 && m_left > 0) ? 1 : 0;
    e.over  = (m_phase == "over") ? 1 : 0;
    e.kill  = m_kill;
    exp_q.push_back(e);
    if (m_kill != 0) kill_q.push_back(m_kill);
  endtask

  always @(posedge clk) model_step();

  exp_t got;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      got = exp_q.pop_front();
      check("mag",   int'(bullets_in_magazine), got.mag);
      check("left",  int'(bullets_left),        got.left);
      check("score", int'(my_score),            got.score);
      check("hunt",  int'(hunt_start),          got.hunt);
      check("show",  int'(show_reload_char),    got.show);
      check("over",  int'(game_over),           got.over);
      check("kill",  int'(duck_killed),         got.kill);
    end
    if (duck_killed != '0) begin
      if (kill_q.size() == 0) check("kill_event_unexpected", int'(duck_killed), 0);
      else check("kill_event", int'(duck_killed), kill_q.pop_front());
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic press_left();
    left_mouse = 1'b1; tick();
    left_mouse = 1'b0; tick();
  endtask

  task automatic press_right();
    right_mouse = 1'b1; tick();
    right_mouse = 1'b0; tick();
  endtask

  task automatic wait_hunt(string name);
    int n;
    n = 0;
    while (!hunt_start && n < 300) begin
      tick();
      n++;
    end
    check(name, int'(hunt_start), 1);
  endtask

  task automatic set_duck(int i, int x, int y);
    duck_xpos[12*i +: 12] = 12'(x);
    duck_ypos[12*i +: 12] = 12'(y);
  endtask

  int n;
  int v;
  int k;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_mag",   int'(bullets_in_magazine), 3);
    check("rst_left",  int'(bullets_left), 7);
    check("rst_score", int'(my_score), 0);
    check("rst_hunt",  int'(hunt_start), 0);
    check("rst_show",  int'(show_reload_char), 0);
    check("rst_kill",  int'(duck_killed), 0);
    check("rst_over",  int'(game_over), 0);
    rst_n = 1'b1;
    tick();

    // Start: countdown length
    game_enable = 1'b1;
    tick();
    n = 0;
    while (!hunt_start && n < 200) begin
      tick();
      n++;
    end
    check("countdown_len", n, 41);
    check("start_mag", int'(bullets_in_magazine), 3);
    check("start_left", int'(bullets_left), 7);

    // Overlapping ducks: lowest index wins
    set_duck(0, 100, 100);
    set_duck(1, 120, 110);
    duck_active = 2'b11;
    mouse_xpos = 12'd130; mouse_ypos = 12'd120;
    left_mouse = 1'b1;
    tick();
    check("overlap_kill",  int'(duck_killed), 1);
    check("overlap_score", int'(my_score), 1);
    check("overlap_mag",   int'(bullets_in_magazine), 2);
    check("overlap_left",  int'(bullets_left), 6);
    left_mouse = 1'b0;
    n = 0;
    while (!hunt_start && n < 200) begin
      n++;
      tick();
    end
    check("death_low_cycles", n, 21);

    // Hitbox edges
    duck_active = 2'b01;
    mouse_xpos = 12'd196; mouse_ypos = 12'd100;
    left_mouse = 1'b1;
    tick();
    check("edge_miss_kill", int'(duck_killed), 0);
    check("edge_miss_mag",  int'(bullets_in_magazine), 1);
    check("edge_miss_left", int'(bullets_left), 5);
    left_mouse = 1'b0;
    tick();
    mouse_xpos = 12'd195; mouse_ypos = 12'd159;
    left_mouse = 1'b1;
    tick();
    check("edge_hit_kill",  int'(duck_killed), 1);
    check("edge_hit_score", int'(my_score), 2);
    check("edge_hit_mag",   int'(bullets_in_magazine), 0);
    check("edge_hit_left",  int'(bullets_left), 4);
    left_mouse = 1'b0;
    wait_hunt("edge_death_end");
    check("empty_show", int'(show_reload_char), 1);

    // Empty magazine click consumes nothing
    mouse_xpos = 12'd2000; mouse_ypos = 12'd2000;
    press_left();
    check("empty_click_left", int'(bullets_left), 4);

    // Reload, clicks during reload ignored
    right_mouse = 1'b1;
    tick();
    check("reload_mag",  int'(bullets_in_magazine), 3);
    check("reload_left", int'(bullets_left), 4);
    check("reload_show", int'(show_reload_char), 0);
    right_mouse = 1'b0;
    left_mouse = 1'b1;
    tick();
    left_mouse = 1'b0;
    tick();
    right_mouse = 1'b1;
    tick();
    right_mouse = 1'b0;
    check("reload_busy_mag",  int'(bullets_in_magazine), 3);
    check("reload_busy_left", int'(bullets_left), 4);
    repeat (6) tick();

    // Partial reload, rejected reload, game over
    press_left();
    press_right();
    repeat (7) tick();
    check("partial_mag", int'(bullets_in_magazine), 3);
    press_left();
    check("pre_reject_mag",  int'(bullets_in_magazine), 2);
    check("pre_reject_left", int'(bullets_left), 2);
    press_right();
    tick();
    check("reject_mag", int'(bullets_in_magazine), 2);
    press_left();
    press_left();
    check("out_left", int'(bullets_left), 0);
    n = 0;
    while (!game_over && n < 10) begin
      tick();
      n++;
    end
    check("game_over", int'(game_over), 1);
    check("over_hunt", int'(hunt_start), 0);

    // Abort to IDLE restores counters
    game_enable = 1'b0;
    tick();
    check("idle_mag",   int'(bullets_in_magazine), 3);
    check("idle_left",  int'(bullets_left), 7);
    check("idle_score", int'(my_score), 0);
    check("idle_over",  int'(game_over), 0);

    // Simultaneous left/right with one round in the magazine
    game_enable = 1'b1;
    tick();
    wait_hunt("restart_hunt");
    press_left();
    press_left();
    left_mouse = 1'b1; right_mouse = 1'b1;
    tick();
    check("simul_mag",  int'(bullets_in_magazine), 0);
    check("simul_left", int'(bullets_left), 4);
    left_mouse = 1'b0; right_mouse = 1'b0;
    repeat (3) tick();
    check("simul_no_reload", int'(bullets_in_magazine), 0);
    check("simul_show", int'(show_reload_char), 1);

    // Asynchronous reset mid-round
    #2 rst_n = 1'b0;
    #1;
    check("async_mag",  int'(bullets_in_magazine), 3);
    check("async_left", int'(bullets_left), 7);
    check("async_score", int'(my_score), 0);
    check("async_hunt", int'(hunt_start), 0);
    check("async_show", int'(show_reload_char), 0);
    tick();
    tick();
    rst_n = 1'b1;

    // Randomised play against the model
    for (int c = 0; c < 2500; c++) begin
      if (c % 60 == 0) begin
        for (int i = 0; i < ND; i++) begin
          if ($urandom_range(0, 3) == 0) v = 4000 + int'($urandom_range(0, 95));
          else v = int'($urandom_range(0, 4095));
          set_duck(i, v, int'($urandom_range(0, 4095)));
        end
        duck_active = 2'($urandom_range(0, 3));
      end
      if (game_over && $urandom_range(0, 3) == 0) game_enable = 1'b0;
      else if ($urandom_range(0, 499) == 0) game_enable = 1'b0;
      else game_enable = 1'b1;
      left_mouse  = ($urandom_range(0, 3) == 0);
      right_mouse = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) != 0) begin
        k = int'($urandom_range(0, ND - 1));
        v = int'(duck_xpos[12*k +: 12]) + int'($urandom_range(0, 115)) - 10;
        mouse_xpos = 12'((v < 0) ? 0 : ((v > 4095) ? 4095 : v));
        v = int'(duck_ypos[12*k +: 12]) + int'($urandom_range(0, 75)) - 8;
        mouse_ypos = 12'((v < 0) ? 0 : ((v > 4095) ? 4095 : v));
      end else begin
        mouse_xpos = 12'($urandom_range(0, 4095));
        mouse_ypos = 12'($urandom_range(0, 4095));
      end
      tick();
    end

    left_mouse = 1'b0;
    right_mouse = 1'b0;
    game_enable = 1'b0;
    repeat (3) tick();
    check("kill_queue_drained", kill_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_duck_game_logic.md
# multi_duck_game_logic

Parametrised game controller for the Duck Hunt game core. It supports N simultaneous ducks, a configurable magazine and ammo pool, partial reloads, a game-over state, and per-duck kill pulses. It sits between the mouse interface / duck movement generators and the HUD and duck renderers. It takes mouse position and buttons plus every duck's position, and drives ammo, score and round-phase outputs.

## Interface
- NUM_DUCKS, 2, number of duck targets (1..8)
- MAG_SIZE, 3, magazine capacity
- TOTAL_AMMO, 27, ammo at game start, magazine included
- DUCK_W, 96, duck hitbox width in pixels
- DUCK_H, 60, duck hitbox height in pixels
- COUNTDOWN_CYC, 130_000_000, start countdown in clock cycles
- DEATH_CYC, 130_000_000, hunting pause after a kill
- RELOAD_CYC, 65_000, reload duration
- SCORE_W, 7, score width
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- mouse_xpos / mouse_ypos  in  12 each  cursor position
- left_mouse / right_mouse  in  1 each  shoot / reload buttons (levels)
- game_enable  in  1  1 = game running; 0 = abort to IDLE
- duck_xpos / duck_ypos  in  12*NUM_DUCKS each  packed positions; duck i is at [12*i +: 12]
- duck_active  in  NUM_DUCKS  1 = duck i is shootable
- bullets_in_magazine  out  $clog2(MAG_SIZE+1)  rounds in magazine
- bullets_left  out  $clog2(TOTAL_AMMO+1)  total rounds remaining
- my_score  out  SCORE_W  kills, saturating
- hunt_start  out  1  high in HUNTING and RELOADING
- show_reload_char  out  1  high while magazine is 0 and bullets_left > 0
- duck_killed  out  NUM_DUCKS  one-cycle kill pulse per duck
- game_over  out  1  high in GAME_OVER

## Operation
- States:
  - IDLE -> COUNTDOWN when game_enable=1.
  - COUNTDOWN -> HUNTING when the counter reaches 0.
  - HUNTING -> DEATH_DELAY on a hit.
  - HUNTING -> RELOADING on a reload request.
  - RELOADING -> HUNTING after RELOAD_CYC.
  - DEATH_DELAY -> HUNTING after DEATH_CYC.
  - HUNTING -> GAME_OVER when bullets_left=0.
  - GAME_OVER holds until game_enable=0.
  - game_enable=0 in any state -> IDLE next edge. IDLE reloads all counters to their reset values.
- Edge detect: each button is registered. A posedge is button=1 while its registered copy is 0.
- Shot: accepted only in HUNTING, on a left posedge with bullets_in_magazine>0. Magazine and bullets_left each decrement by 1.
- Empty magazine: a left posedge with magazine=0 is ignored and consumes nothing.
- Hit test, duck i: duck_active[i] and dx ≤ mx < dx+DUCK_W and dy ≤ my < dy+DUCK_H. Compute in 13 bits so there is no wrap.
- Multiple ducks hit: the lowest index wins. One shot kills one duck.
- On a hit: duck_killed[i] pulses, score increments (saturating at 2^SCORE_W-1), and the FSM enters DEATH_DELAY.
- Reload request: right posedge in HUNTING, accepted only if magazine<MAG_SIZE and bullets_left>magazine; otherwise ignored.
- Magazine after reload: min(MAG_SIZE, bullets_left), applied on entry to RELOADING. bullets_left is unchanged; discarded rounds are not lost.
- Left and right posedges in the same cycle: the shot wins and the reload is dropped.
- Posedges outside HUNTING are ignored.
- Game over: entered from HUNTING when bullets_left=0, after a last-shot hit has finished its DEATH_DELAY.

## Timing
- Reset values:
  - bullets_in_magazine = MAG_SIZE
  - bullets_left = TOTAL_AMMO
  - my_score = 0
  - hunt_start = 0
  - show_reload_char = 0
  - duck_killed = 0
  - game_over = 0
  - state = IDLE
- All outputs are registered. A posedge seen in cycle n is reflected on the outputs after the edge ending cycle n (1-cycle latency).
- COUNTDOWN lasts COUNTDOWN_CYC+1 cycles from entry until hunt_start rises. DEATH_CYC and RELOAD_CYC are counted the same way.
- duck_killed is high for exactly 1 cycle per kill.
- Asserting rst_n=0 mid-round takes effect immediately, independent of clk.

## Configuration
- GAME_AUTO_RELOAD_EN defined: when a shot leaves the magazine at 0 with bullets_left>0, the FSM enters RELOADING automatically. Entry happens after DEATH_DELAY if the shot was a hit. show_reload_char never rises.
- Undefined: only right_mouse reloads.

## Test plan
All scenarios use NUM_DUCKS=2, MAG_SIZE=3, TOTAL_AMMO=7, COUNTDOWN_CYC=40, DEATH_CYC=20, RELOAD_CYC=5, DUCK_W=96, DUCK_H=60.
- Start: reset, then game_enable=1 -> hunt_start rises 41 cycles after entering COUNTDOWN; magazine=3, left=7.
- Overlap hit: duck0 at (100,100), duck1 at (120,110), cursor (130,120), click -> duck_killed=2'b01 for 1 cycle; score=1; magazine=2; left=6; hunt_start low for 21 cycles.
- Edge of hitbox: cursor (196,100) with duck0 at (100,100) -> miss; cursor (195,159) -> hit.
- Miss and reload:
  - 3 misses -> magazine=0, left=4, show_reload_char=1.
  - Right click -> magazine=3 after 1 cycle, left=4, show_reload_char=0.
  - Clicks during the 6 RELOADING cycles are ignored.
- Partial reload and game over:
  - Fire until left=2 with magazine=2, then right click -> ignored.
  - Fire 2 misses -> left=0, game_over=1.
  - game_enable=0 -> IDLE with magazine=3, left=7, score=0.
- Simultaneous press: left and right posedge in the same cycle with magazine=1 -> shot taken (magazine=0), no reload.
